// File: rtl/digital_demodulator.sv
// rtl/digital_demodulator.sv - hard-decision BPSK/QPSK/16QAM/64QAM demapper with serial bit output
module digital_demodulator #(
    parameter int TH16     = 162,
    parameter int TH64_LO  = 79,
    parameter int TH64_MID = 158,
    parameter int TH64_HI  = 237,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mod,
    input  logic             i_sym_vld,
    output logic             o_sym_rdy,
    input  logic [11:0]      i_i,
    input  logic [11:0]      i_q,
    output logic             o_data,
    output logic             o_data_vld,
    input  logic             i_data_rdy,
    output logic [CNT_W-1:0] o_sym_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [11:0] L_TH16     = 12'(TH16);
    localparam logic [11:0] L_TH64_LO  = 12'(TH64_LO);
    localparam logic [11:0] L_TH64_MID = 12'(TH64_MID);
    localparam logic [11:0] L_TH64_HI  = 12'(TH64_HI);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_bits;
    logic [2:0]       r_left;
    logic [CNT_W-1:0] r_cnt;

    logic [11:0] w_abs_i;
    logic [11:0] w_abs_q;
    logic        w_sgn_i;
    logic        w_sgn_q;
    logic [5:0]  w_dec;
    logic [2:0]  w_n;
    logic        w_accept;
    logic        w_xfer;

    // -2048 has no positive 12-bit counterpart, so it saturates to 2047
    function automatic logic [11:0] f_abs(input logic [11:0] v);
        if (!v[11]) begin
            return v;
        end else if (v == 12'h800) begin
            return 12'h7FF;
        end else begin
            return ~v + 12'd1;
        end
    endfunction

    assign w_abs_i = f_abs(i_i);
    assign w_abs_q = f_abs(i_q);
    assign w_sgn_i = ~i_i[11];
    assign w_sgn_q = ~i_q[11];

    // Decisions are left-aligned so the first bit to send always sits in bit 5
    always_comb begin
        w_dec = 6'b0;
        w_n   = 3'd1;
        case (i_mod)
            2'd0: begin
                w_dec = {w_sgn_i, 5'b0};
                w_n   = 3'd1;
            end
            2'd1: begin
                w_dec = {w_sgn_i, w_sgn_q, 4'b0};
                w_n   = 3'd2;
            end
            2'd2: begin
                w_dec = {w_sgn_i, (w_abs_i < L_TH16),
                         w_sgn_q, (w_abs_q < L_TH16), 2'b0};
                w_n   = 3'd4;
            end
            default: begin
                w_dec = {w_sgn_i, (w_abs_i < L_TH64_MID),
                         (w_abs_i >= L_TH64_LO) && (w_abs_i < L_TH64_HI),
                         w_sgn_q, (w_abs_q < L_TH64_MID),
                         (w_abs_q >= L_TH64_LO) && (w_abs_q < L_TH64_HI)};
                w_n   = 3'd6;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && i_sym_vld;
    assign w_xfer   = (r_state == S_SHIFT) && i_data_rdy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_SHIFT;
                end
            end
            default: begin
                if (w_xfer && (r_left == 3'd1)) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bits <= 6'b0;
            r_left <= 3'd0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_bits <= w_dec;
            r_left <= w_n;
            r_cnt  <= r_cnt + 1'b1;
        end else if (w_xfer) begin
            r_bits <= {r_bits[4:0], 1'b0};
            r_left <= r_left - 3'd1;
        end
    end

    assign o_data     = r_bits[5];
    assign o_data_vld = (r_state == S_SHIFT);
    assign o_sym_rdy  = (r_state == S_IDLE);
    assign o_sym_cnt  = r_cnt;

endmodule

// File: tb/tb_digital_demodulator.sv
// tb/tb_digital_demodulator.sv - directed self-checking bench for digital_demodulator
module tb_digital_demodulator;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [1:0]  i_mod = 2'd0;
    logic        i_sym_vld = 1'b0;
    logic        o_sym_rdy;
    logic [11:0] i_i = 12'd0;
    logic [11:0] i_q = 12'd0;
    logic        o_data;
    logic        o_data_vld;
    logic        i_data_rdy = 1'b1;
    logic [15:0] o_sym_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    digital_demodulator dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_mod      (i_mod),
        .i_sym_vld  (i_sym_vld),
        .o_sym_rdy  (o_sym_rdy),
        .i_i        (i_i),
        .i_q        (i_q),
        .o_data     (o_data),
        .o_data_vld (o_data_vld),
        .i_data_rdy (i_data_rdy),
        .o_sym_cnt  (o_sym_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [11:0] ii, input logic [11:0] qq,
                        input bit hold);
        int w = 0;
        @(negedge i_clk);
        while (!o_sym_rdy && w < 20) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 20) check_eq("rdy_timeout", 32'(w), 32'd0);
        i_mod = m;
        i_i = ii;
        i_q = qq;
        i_sym_vld = 1'b1;
        @(posedge i_clk);
        #1;
        exp_cnt++;
        // inputs only need to be valid in the accept cycle
        i_i = 12'($urandom);
        i_q = 12'($urandom);
        i_mod = ~m;
        if (!hold) i_sym_vld = 1'b0;
    endtask

    task automatic collect(input int n, input bit bp, input bit end_chk,
                           output logic [5:0] word, output int cyc);
        int got = 0;
        int t = 0;
        bit stalled = 1'b0;
        logic held = 1'b0;
        word = 6'b0;
        cyc = 0;
        while (got < n && t < 64) begin
            @(negedge i_clk);
            if (t == 0) check_eq("latency", 32'(o_data_vld), 32'd1);
            i_data_rdy = bp ? (t % 3 == 0) : 1'b1;
            if (stalled) check_eq("hold_stable", 32'(o_data), 32'(held));
            if (o_data_vld) cyc++;
            stalled = o_data_vld && !i_data_rdy;
            held = o_data;
            if (o_data_vld && i_data_rdy) begin
                word = {word[4:0], o_data};
                got++;
            end
            t++;
        end
        if (got < n) check_eq("bit_timeout", 32'(got), 32'(n));
        if (end_chk) begin
            @(negedge i_clk);
            i_sym_vld = 1'b0;
            i_data_rdy = 1'b1;
            check_eq("end_vld", 32'(o_data_vld), 32'd0);
            check_eq("end_rdy", 32'(o_sym_rdy), 32'd1);
        end
    endtask

    task automatic run_sym(input string tag, input logic [1:0] m, input logic [11:0] ii,
                           input logic [11:0] qq, input int n, input logic [5:0] exp_word);
        logic [5:0] word;
        int cyc;
        send(m, ii, qq, 1'b0);
        collect(n, 1'b0, 1'b1, word, cyc);
        check_eq(tag, 32'(word), 32'(exp_word));
        check_eq("cnt", 32'(o_sym_cnt), 32'(exp_cnt));
    endtask

    logic [11:0] amp [8];
    logic [2:0]  gray [8];

    initial begin
        logic [5:0] word;
        int cyc;

        amp  = '{-12'sd277, -12'sd197, -12'sd119, -12'sd40, 12'sd40, 12'sd119, 12'sd197, 12'sd277};
        gray = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_vld", 32'(o_data_vld), 32'd0);
        check_eq("rst_rdy", 32'(o_sym_rdy), 32'd1);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_cnt", 32'(o_sym_cnt), 32'd0);
        i_rst_n = 1'b1;

        // BPSK: one vld cycle per symbol
        send(2'd0, 12'd256, 12'd0, 1'b0);
        collect(1, 1'b0, 1'b1, word, cyc);
        check_eq("bpsk_pos", 32'(word), 32'd1);
        check_eq("bpsk_cyc1", 32'(cyc), 32'd1);
        send(2'd0, -12'sd256, 12'd300, 1'b0);
        collect(1, 1'b0, 1'b1, word, cyc);
        check_eq("bpsk_neg", 32'(word), 32'd0);
        check_eq("bpsk_cyc2", 32'(cyc), 32'd1);
        check_eq("bpsk_cnt", 32'(o_sym_cnt), 32'd2);

        run_sym("qpsk_a", 2'd1, 12'd181, -12'sd181, 2, 6'b10);
        run_sym("qpsk_zero", 2'd1, 12'd0, 12'd0, 2, 6'b11);

        run_sym("qam16_a", 2'd2, -12'sd81, 12'd243, 4, 6'b0110);
        run_sym("qam16_161", 2'd2, 12'd161, 12'd0, 4, 6'b1111);
        run_sym("qam16_162", 2'd2, 12'd162, 12'd0, 4, 6'b1011);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                send(2'd3, amp[a], amp[b], 1'b0);
                collect(6, 1'b0, 1'b1, word, cyc);
                check_eq($sformatf("qam64_%0d_%0d", a, b), 32'(word), 32'({gray[a], gray[b]}));
            end
        end
        check_eq("qam64_cnt", 32'(o_sym_cnt), 32'(exp_cnt));
        run_sym("qam64_min", 2'd3, 12'h800, 12'd40, 6, 6'b000110);

        // backpressure with i_sym_vld held high during SHIFT
        send(2'd3, 12'd277, -12'sd40, 1'b1);
        collect(6, 1'b1, 1'b1, word, cyc);
        check_eq("bp_word", 32'(word), 32'b100010);
        check_eq("bp_cnt", 32'(o_sym_cnt), 32'(exp_cnt));

        // reset after the second bit of a 64QAM symbol
        send(2'd3, 12'd277, 12'd277, 1'b0);
        collect(2, 1'b0, 1'b0, word, cyc);
        check_eq("pre_rst_bits", 32'(word), 32'b10);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        check_eq("mid_rst_vld", 32'(o_data_vld), 32'd0);
        check_eq("mid_rst_cnt", 32'(o_sym_cnt), 32'd0);
        check_eq("mid_rst_rdy", 32'(o_sym_rdy), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge i_clk);
        check_eq("post_rst_vld", 32'(o_data_vld), 32'd0);
        run_sym("post_rst_qpsk", 2'd1, -12'sd181, 12'd181, 2, 6'b01);
        @(negedge i_clk);
        check_eq("post_rst_idle", 32'(o_data_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
